// File: rtl/stopwatch_bcd.sv
// Centisecond BCD stopwatch (SS.hh) advanced by rising edges of the 100 Hz tick level.
// Latency: digits, running and rollover update one clock after the sampling edge.
// Backpressure: none; every tick edge seen while running is counted.
module stopwatch_bcd #(
    parameter int TENS_LIMIT = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_In,
    input  logic       start_Stop,
    input  logic       clear,
    output logic [3:0] hundredths_Ones,
    output logic [3:0] hundredths_Tens,
    output logic [3:0] seconds_Ones,
    output logic [3:0] seconds_Tens,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {
        CLEARED = 2'd0,
        RUNNING = 2'd1,
        STOPPED = 2'd2
    } state_t;

    state_t state;
    logic   tick_prev;
    logic   tick_edge;
    logic   carry0, carry1, carry2, carry3, carry4;

    assign tick_edge = tick_In & ~tick_prev;

    // clear discards a coincident tick; the pre-update state decides whether it counts
    assign carry0 = tick_edge & (state == RUNNING) & ~clear;
    assign carry1 = carry0 & (hundredths_Ones == 4'd9);
    assign carry2 = carry1 & (hundredths_Tens == 4'd9);
    assign carry3 = carry2 & (seconds_Ones == 4'd9);
    assign carry4 = carry3 & (seconds_Tens == 4'(TENS_LIMIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= CLEARED;
            running         <= 1'b0;
            rollover        <= 1'b0;
            tick_prev       <= 1'b0;
            hundredths_Ones <= 4'd0;
            hundredths_Tens <= 4'd0;
            seconds_Ones    <= 4'd0;
            seconds_Tens    <= 4'd0;
        end else begin
            tick_prev <= tick_In;
            rollover  <= carry4;

            if (clear) begin
                state   <= CLEARED;
                running <= 1'b0;
            end else if (start_Stop) begin
                if (state == RUNNING) begin
                    state   <= STOPPED;
                    running <= 1'b0;
                end else begin
                    state   <= RUNNING;
                    running <= 1'b1;
                end
            end

            if (clear) begin
                hundredths_Ones <= 4'd0;
                hundredths_Tens <= 4'd0;
                seconds_Ones    <= 4'd0;
                seconds_Tens    <= 4'd0;
            end else begin
                if (carry0) hundredths_Ones <= carry1 ? 4'd0 : hundredths_Ones + 4'd1;
                if (carry1) hundredths_Tens <= carry2 ? 4'd0 : hundredths_Tens + 4'd1;
                if (carry2) seconds_Ones    <= carry3 ? 4'd0 : seconds_Ones + 4'd1;
                if (carry3) seconds_Tens    <= carry4 ? 4'd0 : seconds_Tens + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed scenarios plus random stimulus against a centisecond-count model.
module tb_stopwatch_bcd;

    logic       clock = 1'b0;
    logic       reset, tick_In, start_Stop, clear;
    logic [3:0] hundredths_Ones, hundredths_Tens, seconds_Ones, seconds_Tens;
    logic       running, rollover;

    stopwatch_bcd #(.TENS_LIMIT(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .tick_In        (tick_In),
        .start_Stop     (start_Stop),
        .clear          (clear),
        .hundredths_Ones(hundredths_Ones),
        .hundredths_Tens(hundredths_Tens),
        .seconds_Ones   (seconds_Ones),
        .seconds_Tens   (seconds_Tens),
        .running        (running),
        .rollover       (rollover)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // model: elapsed centiseconds modulo 60 s, plus a run/stop mode
    localparam int WRAP = 6000;
    int   m_cnt = 0;
    int   m_mode = 0;   // 0 cleared, 1 running, 2 stopped
    logic m_prev = 1'b0;
    logic m_roll = 1'b0;

    function automatic logic [15:0] to_digits(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {seconds_Tens, seconds_Ones, hundredths_Tens, hundredths_Ones};
    endfunction

    task automatic model_update(input logic r, t, s, c);
        logic edge_seen;
        if (r) begin
            m_cnt = 0; m_mode = 0; m_prev = 1'b0; m_roll = 1'b0;
        end else begin
            edge_seen = t & ~m_prev;
            m_prev = t;
            m_roll = 1'b0;
            if (c) begin
                m_cnt = 0; m_mode = 0;
            end else begin
                if (edge_seen && m_mode == 1) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == WRAP) begin
                        m_cnt = 0; m_roll = 1'b1;
                    end
                end
                if (s) m_mode = (m_mode == 1) ? 2 : 1;
            end
        end
    endtask

    // drive one cycle of inputs, then compare all outputs against the model
    task automatic step(input logic r, t, s, c);
        logic [15:0] want;
        reset = r; tick_In = t; start_Stop = s; clear = c;
        @(posedge clock);
        #1;
        model_update(r, t, s, c);
        vectors++;
        want = to_digits(m_cnt);
        if (dut_digits() !== want) begin
            miscompares++;
            $display("FAIL digits @%0t: got %h want %h", $time, dut_digits(), want);
        end
        if (running !== (m_mode == 1)) begin
            miscompares++;
            $display("FAIL running @%0t: got %b want %b", $time, running, (m_mode == 1));
        end
        if (rollover !== m_roll) begin
            miscompares++;
            $display("FAIL rollover @%0t: got %b want %b", $time, rollover, m_roll);
        end
    endtask

    // hand-computed expectations that pin both the DUT and the model
    task automatic lit(input string name, input logic [15:0] want, input logic want_run, input logic want_roll);
        vectors++;
        if (dut_digits() !== want || to_digits(m_cnt) !== want) begin
            miscompares++;
            $display("FAIL %s digits: dut %h model %h want %h", name, dut_digits(), to_digits(m_cnt), want);
        end
        if (running !== want_run) begin
            miscompares++;
            $display("FAIL %s running: got %b want %b", name, running, want_run);
        end
        if (rollover !== want_roll) begin
            miscompares++;
            $display("FAIL %s rollover: got %b want %b", name, rollover, want_roll);
        end
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // reset then idle ticks without a start
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lit("reset", 16'h0000, 1'b0, 1'b0);
        pulse_ticks(5);
        lit("idle", 16'h0000, 1'b0, 1'b0);

        // basic counting, tick held high 4 cycles each
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lit("start", 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0);
                if (k == 2 && j == 0) lit("basic3", 16'h0003, 1'b1, 1'b0);
            end
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        lit("basic_hold", 16'h0003, 1'b1, 1'b0);

        // start_Stop coincident with a tick while running
        pulse_ticks(4);
        lit("at07", 16'h0007, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        lit("stop_tick", 16'h0008, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // clear and start_Stop together
        step(1'b0, 1'b0, 1'b1, 1'b1);
        lit("clear_start", 16'h0000, 1'b0, 1'b0);

        // stop / resume; starting on a tick edge does not count it
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_ticks(12);
        lit("at12", 16'h0012, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_ticks(10);
        lit("stopped", 16'h0012, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("resume_edge", 16'h0012, 1'b1, 1'b0);
        pulse_ticks(2);
        lit("resumed", 16'h0014, 1'b1, 1'b0);

        // wrap from 59.99
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_ticks(5999);
        lit("at5999", 16'h5999, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        lit("wrap", 16'h0000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("wrap_after", 16'h0000, 1'b1, 1'b0);

        // reset coincident with a tick edge at 12.34
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_ticks(1234);
        lit("at1234", 16'h1234, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        lit("reset_mid", 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 400) == 0,
                 ($urandom % 2) == 0,
                 ($urandom % 25) == 0,
                 ($urandom % 150) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
